// File: rtl/axis_frame_generator.sv
// AXI-Stream test frame source: on an accepted start it emits frame_len beats of
// an incrementing pattern (seed, seed+1, ...) with tlast on the final beat,
// honours tready backpressure, then idles for an optional gap before signalling done.
// Optional feature macro: AXIS_FRAME_CHECKSUM_EN appends one XOR checksum beat per frame.
module axis_frame_generator #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned LEN_WIDTH  = 12,
    parameter int unsigned GAP_WIDTH  = 8
) (
    input  logic                      m01_axis_aclk,
    input  logic                      m01_axis_areset,
    input  logic                      start,
    input  logic [LEN_WIDTH-1:0]      frame_len,
    input  logic [DATA_WIDTH-1:0]     seed,
    input  logic [GAP_WIDTH-1:0]      gap,
    output logic                      busy,
    output logic                      done,
    output logic [15:0]               frame_count,
    input  logic                      m01_axis_tready,
    output logic [DATA_WIDTH-1:0]     m01_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m01_axis_tstrb,
    output logic                      m01_axis_tvalid,
    output logic                      m01_axis_tlast
);

    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CMP_WIDTH  = LEN_WIDTH + 1;

`ifdef AXIS_FRAME_CHECKSUM_EN
    typedef enum logic [1:0] {IDLE, SEND, CSUM, GAP} state_t;
`else
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
`endif

    state_t                 state, state_d;
    logic [LEN_WIDTH-1:0]   beat_cnt, beat_cnt_d;
    logic [LEN_WIDTH-1:0]   len_q, len_d;
    logic [GAP_WIDTH-1:0]   gap_q, gap_d;
    logic [GAP_WIDTH-1:0]   gap_cnt, gap_cnt_d;
    logic                   tvalid_d, tlast_d, busy_d, done_d;
    logic [DATA_WIDTH-1:0]  tdata_d;
    logic [STRB_WIDTH-1:0]  tstrb_d;
    logic [15:0]            frame_count_d;
    logic                   xfer;
    logic                   end_frame;
`ifdef AXIS_FRAME_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]  csum, csum_d;
`endif

    assign xfer = m01_axis_tvalid && m01_axis_tready;

    // State and registered outputs
    always_ff @(posedge m01_axis_aclk) begin
        if (m01_axis_areset) begin
            state           <= IDLE;
            beat_cnt        <= '0;
            len_q           <= '0;
            gap_q           <= '0;
            gap_cnt         <= '0;
            m01_axis_tvalid <= 1'b0;
            m01_axis_tlast  <= 1'b0;
            m01_axis_tdata  <= '0;
            m01_axis_tstrb  <= '0;
            busy            <= 1'b0;
            done            <= 1'b0;
            frame_count     <= '0;
`ifdef AXIS_FRAME_CHECKSUM_EN
            csum            <= '0;
`endif
        end else begin
            state           <= state_d;
            beat_cnt        <= beat_cnt_d;
            len_q           <= len_d;
            gap_q           <= gap_d;
            gap_cnt         <= gap_cnt_d;
            m01_axis_tvalid <= tvalid_d;
            m01_axis_tlast  <= tlast_d;
            m01_axis_tdata  <= tdata_d;
            m01_axis_tstrb  <= tstrb_d;
            busy            <= busy_d;
            done            <= done_d;
            frame_count     <= frame_count_d;
`ifdef AXIS_FRAME_CHECKSUM_EN
            csum            <= csum_d;
`endif
        end
    end

    // Next-state and next-output computation; outputs hold unless a transfer or transition moves them
    always_comb begin
        state_d       = state;
        beat_cnt_d    = beat_cnt;
        len_d         = len_q;
        gap_d         = gap_q;
        gap_cnt_d     = gap_cnt;
        tvalid_d      = m01_axis_tvalid;
        tlast_d       = m01_axis_tlast;
        tdata_d       = m01_axis_tdata;
        tstrb_d       = m01_axis_tstrb;
        done_d        = 1'b0;
        frame_count_d = frame_count;
        end_frame     = 1'b0;
`ifdef AXIS_FRAME_CHECKSUM_EN
        csum_d        = csum;
`endif

        case (state)
            IDLE: begin
                if (start && (frame_len != '0)) begin
                    state_d    = SEND;
                    len_d      = frame_len;
                    gap_d      = gap;
                    beat_cnt_d = '0;
                    tvalid_d   = 1'b1;
                    tdata_d    = seed;
                    tstrb_d    = '1;
`ifdef AXIS_FRAME_CHECKSUM_EN
                    tlast_d    = 1'b0;
                    csum_d     = '0;
`else
                    tlast_d    = (frame_len == LEN_WIDTH'(1));
`endif
                end
            end
            SEND: begin
                if (xfer) begin
                    if (beat_cnt == (len_q - LEN_WIDTH'(1))) begin
`ifdef AXIS_FRAME_CHECKSUM_EN
                        // Checksum beat folds in the final data beat just transferred
                        state_d = CSUM;
                        tdata_d = csum ^ m01_axis_tdata;
                        csum_d  = csum ^ m01_axis_tdata;
                        tlast_d = 1'b1;
`else
                        end_frame = 1'b1;
`endif
                    end else begin
                        beat_cnt_d = beat_cnt + LEN_WIDTH'(1);
                        tdata_d    = m01_axis_tdata + DATA_WIDTH'(1);
`ifdef AXIS_FRAME_CHECKSUM_EN
                        csum_d     = csum ^ m01_axis_tdata;
                        tlast_d    = 1'b0;
`else
                        // Next beat index is beat_cnt+1; it is last when beat_cnt+2 == len
                        tlast_d    = ((CMP_WIDTH'(beat_cnt) + CMP_WIDTH'(2)) == CMP_WIDTH'(len_q));
`endif
                    end
                end
            end
`ifdef AXIS_FRAME_CHECKSUM_EN
            CSUM: begin
                if (xfer) begin
                    end_frame = 1'b1;
                end
            end
`endif
            GAP: begin
                if (gap_cnt == GAP_WIDTH'(1)) begin
                    state_d       = IDLE;
                    done_d        = 1'b1;
                    frame_count_d = frame_count + 16'd1;
                end else begin
                    gap_cnt_d = gap_cnt - GAP_WIDTH'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Final beat accepted: drop the bus and either finish now or count out the gap
        if (end_frame) begin
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            tstrb_d  = '0;
            if (gap_q == '0) begin
                state_d       = IDLE;
                done_d        = 1'b1;
                frame_count_d = frame_count + 16'd1;
            end else begin
                state_d   = GAP;
                gap_cnt_d = gap_q;
            end
        end

        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_axis_frame_generator.sv
// Directed testbench for axis_frame_generator (default build, checksum beat only
// exercised when AXIS_FRAME_CHECKSUM_EN is defined).
module tb_axis_frame_generator;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] frame_len;
    logic [31:0] seed;
    logic [7:0]  gap;
    logic        busy, done;
    logic [15:0] frame_count;
    logic        tready;
    logic [31:0] tdata;
    logic [3:0]  tstrb;
    logic        tvalid, tlast;

    int tests_run = 0;
    int tests_failed = 0;

    // Capture of one frame, filled by run_frame
    logic [31:0] cap_data [0:15];
    logic        cap_last [0:15];
    int          cap_cyc  [0:15];
    int          n_beats;
    int          done_cyc;
    int          valid_cycles;
    int          stall_err;
    logic        busy_first;

    always #5 clk = ~clk;

    axis_frame_generator dut (
        .m01_axis_aclk   (clk),
        .m01_axis_areset (rst),
        .start           (start),
        .frame_len       (frame_len),
        .seed            (seed),
        .gap             (gap),
        .busy            (busy),
        .done            (done),
        .frame_count     (frame_count),
        .m01_axis_tready (tready),
        .m01_axis_tdata  (tdata),
        .m01_axis_tstrb  (tstrb),
        .m01_axis_tvalid (tvalid),
        .m01_axis_tlast  (tlast)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Starts a frame from IDLE and records beats until done (cycle 1 = first cycle after acceptance).
    // tready follows rdy_pat[k % pat_len] on the k-th cycle of the frame.
    task automatic run_frame(input logic [11:0] len, input logic [31:0] sd, input logic [7:0] g,
                             input logic [15:0] rdy_pat, input int pat_len, input bit hold_start);
        logic        prev_stalled;
        logic [31:0] prev_data;
        logic        prev_last;
        int          cyc;
        n_beats = 0; done_cyc = -1; valid_cycles = 0; stall_err = 0; prev_stalled = 1'b0;
        prev_data = '0; prev_last = 1'b0;
        start = 1'b1; frame_len = len; seed = sd; gap = g;
        step();
        if (!hold_start) start = 1'b0;
        busy_first = busy;
        for (cyc = 1; cyc < 200; cyc++) begin
            if (done) begin
                done_cyc = cyc;
                break;
            end
            tready = rdy_pat[(cyc - 1) % pat_len];
            if (prev_stalled && (!tvalid || tdata !== prev_data || tlast !== prev_last)) stall_err++;
            if (tvalid) begin
                valid_cycles++;
                if (tstrb !== 4'hF) stall_err++;
                if (tready) begin
                    if (n_beats < 16) begin
                        cap_data[n_beats] = tdata;
                        cap_last[n_beats] = tlast;
                        cap_cyc[n_beats]  = cyc;
                    end
                    n_beats++;
                    prev_stalled = 1'b0;
                end else begin
                    prev_stalled = 1'b1;
                    prev_data = tdata;
                    prev_last = tlast;
                end
            end else begin
                if (tstrb !== 4'h0) stall_err++;
                prev_stalled = 1'b0;
            end
            step();
        end
        tready = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; frame_len = '0; seed = '0; gap = '0; tready = 1'b1;
        step(); step();
        tests_run++; if (tvalid !== 1'b0) begin tests_failed++; $display("FAIL reset_tvalid got %b want 0", tvalid); end
        tests_run++; if ({busy, done, tlast} !== 3'b000) begin tests_failed++; $display("FAIL reset_flags got %b want 000", {busy, done, tlast}); end
        tests_run++; if ({tdata, tstrb, frame_count} !== 52'h0) begin tests_failed++; $display("FAIL reset_data got %h/%h/%h want 0", tdata, tstrb, frame_count); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_zero_len();
        start = 1'b1; frame_len = 12'd0; seed = 32'h1234; gap = 8'd0;
        step();
        start = 1'b0;
        tests_run++; if ({busy, tvalid} !== 2'b00) begin tests_failed++; $display("FAIL zero_len_busy got %b want 00", {busy, tvalid}); end
        step();
        tests_run++; if ({done, frame_count} !== 17'h0) begin tests_failed++; $display("FAIL zero_len_done got %b/%h want 0/0", done, frame_count); end
    endtask

    task automatic test_basic();
        run_frame(12'd4, 32'h10, 8'd0, 16'h0001, 1, 1'b0);
        tests_run++; if (n_beats !== 4) begin tests_failed++; $display("FAIL basic_count got %0d want 4", n_beats); end
        for (int i = 0; i < 4; i++) begin
            tests_run++;
            if (cap_data[i] !== 32'h10 + 32'(i) || cap_last[i] !== (i == 3) || cap_cyc[i] !== i + 1) begin
                tests_failed++;
                $display("FAIL basic_beat%0d got %h last %b cyc %0d want %h last %b cyc %0d",
                         i, cap_data[i], cap_last[i], cap_cyc[i], 32'h10 + 32'(i), (i == 3), i + 1);
            end
        end
        tests_run++; if (busy_first !== 1'b1) begin tests_failed++; $display("FAIL basic_busy got %b want 1", busy_first); end
        tests_run++; if (done_cyc !== 5) begin tests_failed++; $display("FAIL basic_done_cyc got %0d want 5", done_cyc); end
        tests_run++; if ({busy, frame_count} !== {1'b0, 16'd1}) begin tests_failed++; $display("FAIL basic_fc got %b/%0d want 0/1", busy, frame_count); end
        step();
        tests_run++; if (done !== 1'b0) begin tests_failed++; $display("FAIL basic_done_pulse got %b want 0", done); end
    endtask

    task automatic test_backpressure();
        // tready per cycle: 1,0,0,1,0,1
        run_frame(12'd3, 32'hA0, 8'd0, 16'h0029, 6, 1'b0);
        tests_run++; if (n_beats !== 3) begin tests_failed++; $display("FAIL bp_count got %0d want 3", n_beats); end
        tests_run++;
        if (cap_data[0] !== 32'hA0 || cap_data[1] !== 32'hA1 || cap_data[2] !== 32'hA2) begin
            tests_failed++;
            $display("FAIL bp_data got %h %h %h want a0 a1 a2", cap_data[0], cap_data[1], cap_data[2]);
        end
        tests_run++;
        if (cap_cyc[0] !== 1 || cap_cyc[1] !== 4 || cap_cyc[2] !== 6 || cap_last[2] !== 1'b1 || cap_last[1] !== 1'b0) begin
            tests_failed++;
            $display("FAIL bp_timing got cyc %0d %0d %0d last %b%b want 1 4 6 last 01",
                     cap_cyc[0], cap_cyc[1], cap_cyc[2], cap_last[1], cap_last[2]);
        end
        tests_run++; if (stall_err !== 0) begin tests_failed++; $display("FAIL bp_stable got %0d errors want 0", stall_err); end
        tests_run++; if (done_cyc !== 7 || frame_count !== 16'd2) begin tests_failed++; $display("FAIL bp_done got cyc %0d fc %0d want 7/2", done_cyc, frame_count); end
    endtask

    task automatic test_wrap_and_single();
        run_frame(12'd2, 32'hFFFF_FFFF, 8'd0, 16'h0001, 1, 1'b0);
        tests_run++;
        if (n_beats !== 2 || cap_data[0] !== 32'hFFFF_FFFF || cap_data[1] !== 32'h0 || cap_last[0] !== 1'b0 || cap_last[1] !== 1'b1) begin
            tests_failed++;
            $display("FAIL wrap got n %0d %h %h last %b%b want 2 ffffffff 0 last 01",
                     n_beats, cap_data[0], cap_data[1], cap_last[0], cap_last[1]);
        end
        run_frame(12'd1, 32'h55, 8'd0, 16'h0001, 1, 1'b0);
        tests_run++;
        if (n_beats !== 1 || cap_data[0] !== 32'h55 || cap_last[0] !== 1'b1 || done_cyc !== 2) begin
            tests_failed++;
            $display("FAIL single got n %0d %h last %b done %0d want 1 55 1 2", n_beats, cap_data[0], cap_last[0], done_cyc);
        end
        tests_run++; if (frame_count !== 16'd4) begin tests_failed++; $display("FAIL single_fc got %0d want 4", frame_count); end
    endtask

    task automatic test_gap();
        int k;
        run_frame(12'd2, 32'h300, 8'd3, 16'h0001, 1, 1'b1);
        tests_run++; if (n_beats !== 2 || cap_cyc[1] !== 2) begin tests_failed++; $display("FAIL gap_beats got n %0d cyc %0d want 2/2", n_beats, cap_cyc[1]); end
        tests_run++; if (valid_cycles !== 2) begin tests_failed++; $display("FAIL gap_idle got %0d valid cycles want 2", valid_cycles); end
        tests_run++; if (done_cyc !== 6) begin tests_failed++; $display("FAIL gap_done_cyc got %0d want 6", done_cyc); end
        tests_run++; if ({busy, frame_count} !== {1'b0, 16'd5}) begin tests_failed++; $display("FAIL gap_fc got %b/%0d want 0/5", busy, frame_count); end
        // start still high in the done cycle: second frame accepted from IDLE
        seed = 32'h400; gap = 8'd0;
        step();
        start = 1'b0;
        tests_run++; if ({tvalid, busy} !== 2'b11 || tdata !== 32'h400) begin tests_failed++; $display("FAIL gap_restart got v%b b%b %h want 1 1 400", tvalid, busy, tdata); end
        for (k = 0; k < 20 && !done; k++) step();
        tests_run++; if (done !== 1'b1 || frame_count !== 16'd6) begin tests_failed++; $display("FAIL gap_second got done %b fc %0d want 1/6", done, frame_count); end
        step();
    endtask

    task automatic test_reset_mid_frame();
        start = 1'b1; frame_len = 12'd8; seed = 32'h100; gap = 8'd0; tready = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        tests_run++; if (tdata !== 32'h102 || tvalid !== 1'b1) begin tests_failed++; $display("FAIL rst_mid_pre got %h v%b want 102 v1", tdata, tvalid); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        tests_run++; if ({tvalid, busy, done} !== 3'b000 || frame_count !== 16'd0) begin tests_failed++; $display("FAIL rst_mid got v%b b%b d%b fc %0d want 0 0 0 0", tvalid, busy, done, frame_count); end
        step(); step();
        tests_run++; if ({tvalid, done} !== 2'b00) begin tests_failed++; $display("FAIL rst_mid_quiet got v%b d%b want 00", tvalid, done); end
        run_frame(12'd2, 32'h200, 8'd0, 16'h0001, 1, 1'b0);
        tests_run++;
        if (n_beats !== 2 || cap_data[0] !== 32'h200 || cap_data[1] !== 32'h201 || frame_count !== 16'd1) begin
            tests_failed++;
            $display("FAIL rst_mid_after got n %0d %h %h fc %0d want 2 200 201 1", n_beats, cap_data[0], cap_data[1], frame_count);
        end
    endtask

`ifdef AXIS_FRAME_CHECKSUM_EN
    task automatic test_checksum();
        run_frame(12'd3, 32'd5, 8'd0, 16'h0001, 1, 1'b0);
        tests_run++;
        if (n_beats !== 4 || cap_data[0] !== 32'd5 || cap_data[1] !== 32'd6 || cap_data[2] !== 32'd7 || cap_data[3] !== 32'd4) begin
            tests_failed++;
            $display("FAIL csum_data got n %0d %h %h %h %h want 4 5 6 7 4", n_beats, cap_data[0], cap_data[1], cap_data[2], cap_data[3]);
        end
        tests_run++;
        if (cap_last[2] !== 1'b0 || cap_last[3] !== 1'b1 || done_cyc !== 5) begin
            tests_failed++;
            $display("FAIL csum_last got %b%b done %0d want 01 5", cap_last[2], cap_last[3], done_cyc);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_zero_len();
        test_basic();
        test_backpressure();
        test_wrap_and_single();
        test_gap();
        test_reset_mid_frame();
`ifdef AXIS_FRAME_CHECKSUM_EN
        test_checksum();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
